// File: rtl/ldpc_frame_buffer_ctrl.sv
// ldpc_frame_buffer_ctrl
//   Sits in front of a single-port, synchronous-read RAM and owns all of its
//   ports. One LLR frame of FRAME_LEN words is written to addresses
//   0..FRAME_LEN-1 from the input stream. The frame is then read back in
//   address order onto the output stream. A 2-entry skid FIFO covers the
//   RAM's one-cycle read latency, so output backpressure never drops or
//   repeats a word.
//
// Ports
//   clk, rst         : clock and synchronous active-high reset
//   in_valid/ready   : input stream handshake; in_data is the word
//   out_valid/ready  : output stream handshake; out_data is the FIFO head
//   frame_done       : one-cycle pulse after the last word of a frame pops
//   ram_cs, ram_we   : RAM chip select / write enable (combinational)
//   ram_address      : RAM address (combinational)
//   ram_data_in      : RAM write data (combinational)
//   ram_data_out     : RAM read data, valid the cycle after a read issues
module ldpc_frame_buffer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  frame_done,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    // FRAME_LEN = 2**ADDR_WIDTH truncates to all-ones, so pointers wrap cleanly.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] pop_cnt;
    logic                  rd_inflight;
    logic                  tail_valid;
    logic [DATA_WIDTH-1:0] tail_data;

    logic       wr_fire;
    logic       rd_fire;
    logic       pop;
    logic       push;
    logic [1:0] occupancy;

    // NOTE: every signal driven here is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        pop       = out_valid && out_ready;
        push      = rd_inflight;
        // Words already committed to the output path: FIFO entries plus the
        // read whose data arrives at the next edge.
        occupancy = {1'b0, out_valid} + {1'b0, tail_valid} + {1'b0, rd_inflight};

        in_ready  = !rst && (state == FILL);
        wr_fire   = in_valid && in_ready;
        // Issue only if the word still fits after this cycle's pop.
        rd_fire   = !rst && (state == DRAIN) && (occupancy <= ({1'b0, pop} + 2'd1));

        ram_cs      = wr_fire || rd_fire;
        ram_we      = wr_fire;
        ram_address = '0;
        ram_data_in = '0;
        if (wr_fire) begin
            ram_address = wr_ptr;
            ram_data_in = in_data;
        end else if (rd_fire) begin
            ram_address = rd_ptr;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (wr_fire && (wr_ptr == LAST_ADDR)) state_next = DRAIN;
            DRAIN:   if (rd_fire && (rd_ptr == LAST_ADDR)) state_next = FLUSH;
            // Leave once the final pop empties the pipe; FILL starts next cycle.
            FLUSH:   if (occupancy == {1'b0, pop})          state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pop_cnt     <= '0;
            rd_inflight <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            tail_valid  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_ONE;
            if (rd_fire) rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_ONE;
            rd_inflight <= rd_fire;

            frame_done <= pop && (pop_cnt == LAST_ADDR);
            if (pop) pop_cnt <= (pop_cnt == LAST_ADDR) ? '0 : pop_cnt + ADDR_ONE;

            // Head register is out_data; tail catches a word that arrives while
            // the head is stalled.
            if (pop) begin
                if (tail_valid) begin
                    out_data   <= tail_data;
                    tail_valid <= push;
                end else begin
                    out_valid <= push;
                    if (push) out_data <= ram_data_out;
                end
            end else if (push) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= ram_data_out;
                end else begin
                    tail_valid <= 1'b1;
                end
            end
        end
    end

    // NOTE: tail_data is storage only; tail_valid qualifies it, so it carries
    // no reset.
    always_ff @(posedge clk) begin
        if (push && ((pop && tail_valid) || (!pop && out_valid))) tail_data <= ram_data_out;
    end

endmodule

// File: tb/tb_ldpc_frame_buffer_ctrl.sv
// Self-checking bench for ldpc_frame_buffer_ctrl. Two instances: the default
// 256-word frame and a 4-word frame on a 2-bit address. Each drives a small
// behavioural RAM. Expected values come from counts of issued reads and pops
// and from the words fed in.
module tb_ldpc_frame_buffer_ctrl;

    localparam int FL  = 256;
    localparam int SFL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, frame_done, ram_cs, ram_we;
    logic [7:0] in_data, out_data, ram_data_in, ram_data_out, ram_address;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_frame_done, s_ram_cs, s_ram_we;
    logic [7:0] s_in_data, s_out_data, s_ram_data_in, s_ram_data_out;
    logic [1:0] s_ram_address;

    logic [7:0] mem   [FL];
    logic [7:0] s_mem [SFL];

    int n_checks = 0;
    int n_fail   = 0;
    int seed_init;

    ldpc_frame_buffer_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .frame_done(frame_done),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    ldpc_frame_buffer_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FRAME_LEN(SFL)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .frame_done(s_frame_done), .ram_cs(s_ram_cs), .ram_we(s_ram_we),
        .ram_address(s_ram_address), .ram_data_in(s_ram_data_in), .ram_data_out(s_ram_data_out)
    );

    // Synchronous-read single-port RAM models.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_address] <= ram_data_in;
            else        ram_data_out     <= mem[ram_address];
        end
    end

    always @(posedge clk) begin
        if (s_ram_cs) begin
            if (s_ram_we) s_mem[s_ram_address] <= s_ram_data_in;
            else          s_ram_data_out       <= s_mem[s_ram_address];
        end
    end

    // Writes one full frame, then drains it. abort_after > 0 returns right
    // after that many pops, leaving the DUT mid-DRAIN.
    task automatic run_frame(input string name, input bit gaps, input bit bp,
                             input bit ff, input bit rand_data, input int abort_after);
        logic [7:0] words [FL];
        logic [7:0] data_prev;
        int  idx, cyc, t, reads, pops, done_cnt, mem_bad;
        bit  last_pop_prev, stall_prev, pop_now, exp_issue, fin;
        for (int i = 0; i < FL; i++) words[i] = rand_data ? 8'($urandom) : 8'(i);

        idx = 0;
        cyc = 0;
        while (idx < FL && cyc < 2000) begin
            @(posedge clk); #1;
            in_valid  = !(gaps && (cyc % 3 == 2));
            in_data   = words[idx];
            out_ready = 1'b1;
            #1;
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s fill_flags idx=%0d: in_ready/out_valid=%b/%b, want 1/0",
                         name, idx, in_ready, out_valid);
            end
            n_checks++;
            if (in_valid) begin
                if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_address !== 8'(idx) || ram_data_in !== words[idx]) begin
                    n_fail++;
                    $display("FAIL %s fill_write: cs=%b we=%b addr=%0d din=%h, want 1 1 %0d %h",
                             name, ram_cs, ram_we, ram_address, ram_data_in, idx, words[idx]);
                end
                idx++;
            end else if (ram_cs !== 1'b0 || ram_we !== 1'b0) begin
                n_fail++;
                $display("FAIL %s fill_idle: cs=%b we=%b, want 0 0", name, ram_cs, ram_we);
            end
            cyc++;
        end
        n_checks++;
        if (idx != FL) begin
            n_fail++;
            $display("FAIL %s fill_timeout: accepted %0d words, want %0d", name, idx, FL);
        end

        t = 0; reads = 0; pops = 0; done_cnt = 0;
        last_pop_prev = 1'b0; stall_prev = 1'b0; data_prev = '0; fin = 1'b0;
        while (!fin && t < 3000) begin
            @(posedge clk); #1;
            in_valid  = ff && !last_pop_prev;
            in_data   = 8'hFF;
            out_ready = bp ? ($urandom_range(0, 99) < 55) : 1'b1;
            #1;
            pop_now   = out_valid && out_ready;
            // Outstanding words = reads issued - words popped; a read may issue
            // when that, less this cycle's pop, is at most 1.
            exp_issue = (reads < FL) && ((reads - pops) - int'(pop_now) <= 1);

            n_checks++;
            if (ram_cs !== exp_issue || ram_we !== 1'b0 || (exp_issue && ram_address !== 8'(reads))) begin
                n_fail++;
                $display("FAIL %s drain_ram t=%0d: cs=%b we=%b addr=%0d, want cs=%b we=0 addr=%0d",
                         name, t, ram_cs, ram_we, ram_address, exp_issue, reads);
            end
            n_checks++;
            if (in_ready !== last_pop_prev || frame_done !== last_pop_prev) begin
                n_fail++;
                $display("FAIL %s drain_flags t=%0d: in_ready=%b frame_done=%b, want %b %b",
                         name, t, in_ready, frame_done, last_pop_prev, last_pop_prev);
            end
            if (stall_prev) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== data_prev) begin
                    n_fail++;
                    $display("FAIL %s stall_hold t=%0d: valid=%b data=%h, want 1 %h",
                             name, t, out_valid, out_data, data_prev);
                end
            end
            if (!bp) begin
                n_checks++;
                if (out_valid !== (t >= 2 && t <= FL + 1)) begin
                    n_fail++;
                    $display("FAIL %s out_valid_timing t=%0d: got %b, want %b",
                             name, t, out_valid, (t >= 2 && t <= FL + 1));
                end
            end
            if (pop_now) begin
                n_checks++;
                if (pops >= FL || out_data !== words[pops % FL]) begin
                    n_fail++;
                    $display("FAIL %s pop_data #%0d: got %h, want %h",
                             name, pops, out_data, words[pops % FL]);
                end
            end

            if (exp_issue) reads++;
            if (pop_now) pops++;
            if (frame_done === 1'b1) done_cnt++;
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
            if (abort_after > 0 && pops == abort_after) return;
            fin           = last_pop_prev;
            last_pop_prev = pop_now && (pops == FL);
            t++;
        end

        n_checks++;
        if (pops != FL || done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s drain_totals: pops=%0d frame_done=%0d, want %0d 1", name, pops, done_cnt, FL);
        end
        mem_bad = 0;
        for (int i = 0; i < FL; i++) if (mem[i] !== words[i]) mem_bad++;
        n_checks++;
        if (mem_bad != 0) begin
            n_fail++;
            $display("FAIL %s ram_contents: %0d words differ, want 0", name, mem_bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        @(posedge clk); #2;
        n_checks++;
        if (in_ready !== 1'b0 || ram_cs !== 1'b0 || ram_we !== 1'b0 || ram_address !== 8'd0 ||
            s_in_ready !== 1'b0 || s_ram_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: in_ready=%b cs=%b we=%b addr=%0d s_in_ready=%b s_cs=%b, want all 0",
                     in_ready, ram_cs, ram_we, ram_address, s_in_ready, s_ram_cs);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || frame_done !== 1'b0 || in_ready !== 1'b1 || ram_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: out_valid=%b out_data=%h frame_done=%b in_ready=%b cs=%b, want 0 00 0 1 0",
                     out_valid, out_data, frame_done, in_ready, ram_cs);
        end
    endtask

    task automatic test_basic_stream();
        run_frame("basic", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_frame("backpressure", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_input_gaps();
        run_frame("input_gaps", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_in_valid_ignored();
        run_frame("ignore_in", 1'b0, 1'b0, 1'b1, 1'b1, 0);
    endtask

    task automatic test_reset_mid_drain();
        run_frame("pre_reset", 1'b0, 1'b0, 1'b0, 1'b1, 3);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || ram_cs !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_held: in_ready=%b cs=%b we=%b, want 0 0 0", in_ready, ram_cs, ram_we);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ram_cs !== 1'b0 || out_data !== 8'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_after: out_valid=%b in_ready=%b cs=%b out_data=%h frame_done=%b, want 0 1 0 00 0",
                     out_valid, in_ready, ram_cs, out_data, frame_done);
        end
        run_frame("post_reset", 1'b0, 1'b1, 1'b0, 1'b1, 0);
    endtask

    task automatic test_back_to_back_len4();
        logic [7:0] words [2*SFL];
        int  accepted, pops, done_cnt;
        bit  model_fill, last_pop_prev, lp, pop_now, fin;
        words[0] = 8'd10; words[1] = 8'd11; words[2] = 8'd12; words[3] = 8'd13;
        words[4] = 8'd20; words[5] = 8'd21; words[6] = 8'd22; words[7] = 8'd23;
        accepted = 0; pops = 0; done_cnt = 0;
        model_fill = 1'b1; last_pop_prev = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            @(posedge clk); #1;
            s_in_valid  = (accepted < 2*SFL);
            s_in_data   = words[accepted % (2*SFL)];
            s_out_ready = 1'b1;
            #1;
            lp = last_pop_prev;
            n_checks++;
            if (s_in_ready !== model_fill || s_ram_we !== (model_fill && s_in_valid) || s_frame_done !== lp) begin
                n_fail++;
                $display("FAIL len4_flags cyc=%0d: in_ready=%b we=%b frame_done=%b, want %b %b %b",
                         cyc, s_in_ready, s_ram_we, s_frame_done, model_fill, model_fill && s_in_valid, lp);
            end
            if (model_fill && s_in_valid) begin
                n_checks++;
                if (s_ram_address !== 2'(accepted % SFL) || s_ram_data_in !== words[accepted]) begin
                    n_fail++;
                    $display("FAIL len4_write #%0d: addr=%0d din=%0d, want %0d %0d",
                             accepted, s_ram_address, s_ram_data_in, accepted % SFL, words[accepted]);
                end
                accepted++;
                if (accepted % SFL == 0) model_fill = 1'b0;
            end
            pop_now = s_out_valid && s_out_ready;
            if (pop_now) begin
                n_checks++;
                if (pops >= 2*SFL || s_out_data !== words[pops % (2*SFL)]) begin
                    n_fail++;
                    $display("FAIL len4_pop #%0d: got %0d, want %0d", pops, s_out_data, words[pops % (2*SFL)]);
                end
                pops++;
            end
            if (s_frame_done === 1'b1) done_cnt++;
            last_pop_prev = pop_now && (pops % SFL == 0);
            if (last_pop_prev) model_fill = 1'b1;
            fin = lp && (pops == 2*SFL);
        end
        s_in_valid = 1'b0;
        n_checks++;
        if (pops != 2*SFL || done_cnt != 2 || accepted != 2*SFL) begin
            n_fail++;
            $display("FAIL len4_totals: pops=%0d frame_done=%0d accepted=%0d, want 8 2 8", pops, done_cnt, accepted);
        end
    endtask

    initial begin
        seed_init   = $urandom(32'd20240611);
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b1;

        test_reset();
        test_basic_stream();
        test_backpressure();
        test_input_gaps();
        test_in_valid_ignored();
        test_back_to_back_len4();
        test_reset_mid_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
